// File: rtl/dmi_cmd_bridge_if.sv
// rtl/dmi_cmd_bridge_if.sv - command, DMI request/response and result channels of dmi_cmd_bridge; stats signals exist only with DMI_CMD_BRIDGE_STATS_EN
interface dmi_cmd_bridge_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int CMD_DEPTH  = 4
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [ADDR_WIDTH-1:0]      cmd_addr;
    logic [1:0]                 cmd_op;
    logic [DATA_WIDTH-1:0]      cmd_data;

    logic                       debug_req_valid;
    logic                       debug_req_ready;
    logic [ADDR_WIDTH-1:0]      debug_req_bits_addr;
    logic [1:0]                 debug_req_bits_op;
    logic [DATA_WIDTH-1:0]      debug_req_bits_data;

    logic                       debug_resp_valid;
    logic                       debug_resp_ready;
    logic [1:0]                 debug_resp_bits_resp;
    logic [DATA_WIDTH-1:0]      debug_resp_bits_data;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [1:0]                 rsp_status;
    logic [DATA_WIDTH-1:0]      rsp_data;

    logic [$clog2(CMD_DEPTH):0] cmd_count;
    logic                       busy;
`ifdef DMI_CMD_BRIDGE_STATS_EN
    logic [15:0]                stat_retries;
    logic [15:0]                stat_timeouts;
    logic [31:0]                stat_done;
`endif

    // Bridge-side view
    modport slave (
        input  cmd_valid, cmd_addr, cmd_op, cmd_data,
        output cmd_ready,
        output debug_req_valid, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data,
        input  debug_req_ready,
        input  debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data,
        output debug_resp_ready,
        output rsp_valid, rsp_status, rsp_data,
        input  rsp_ready,
        output cmd_count, busy
`ifdef DMI_CMD_BRIDGE_STATS_EN
        , output stat_retries, stat_timeouts, stat_done
`endif
    );

    // Host and debug-module side view
    modport master (
        output cmd_valid, cmd_addr, cmd_op, cmd_data,
        input  cmd_ready,
        input  debug_req_valid, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data,
        output debug_req_ready,
        output debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data,
        input  debug_resp_ready,
        input  rsp_valid, rsp_status, rsp_data,
        output rsp_ready,
        input  cmd_count, busy
`ifdef DMI_CMD_BRIDGE_STATS_EN
        , input stat_retries, stat_timeouts, stat_done
`endif
    );
endinterface

// File: rtl/dmi_cmd_bridge.sv
// rtl/dmi_cmd_bridge.sv - DMI command bridge: command FIFO, single outstanding request, busy retry with backoff, timeout
// Optional saturating statistics counters are enabled by defining DMI_CMD_BRIDGE_STATS_EN.
module dmi_cmd_bridge #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 7,
    parameter int CMD_DEPTH      = 4,
    parameter int RETRY_LIMIT    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    dmi_cmd_bridge_if.slave   bus
);
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = $clog2(CMD_DEPTH) + 1;
    localparam int RC_W  = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
    localparam int BO_W  = (RETRY_LIMIT > 0) ? RETRY_LIMIT : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int ENT_W = ADDR_WIDTH + 2 + DATA_WIDTH;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_BACKOFF = 3'd3;
    localparam logic [2:0] ST_RSP     = 3'd4;

    logic [ENT_W-1:0]      fifo_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full, empty, push, pop;
    logic [ENT_W-1:0]      head;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [1:0]            req_op_q, req_op_d;
    logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
    logic [RC_W-1:0]       retry_cnt_q, retry_cnt_d;
    logic [BO_W-1:0]       backoff_q, backoff_d;
    logic [TO_W-1:0]       timer_q, timer_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  retry_ok;
    logic                  timer_expired;

    assign full  = (count_q == CNT_W'(CMD_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.cmd_valid && !full;
    assign pop   = (state_q == ST_IDLE) && !empty;
    assign head  = fifo_mem_q[rd_ptr_q];

    assign retry_ok      = (bus.debug_resp_bits_resp == 2'd3) && (retry_cnt_q < RC_W'(RETRY_LIMIT));
    assign timer_expired = (timer_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Storage is not reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {bus.cmd_addr, bus.cmd_op, bus.cmd_data};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_op_d     = req_op_q;
        req_data_d   = req_data_q;
        retry_cnt_d  = retry_cnt_q;
        backoff_d    = backoff_q;
        timer_d      = timer_q;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    req_addr_d  = head[ENT_W-1 -: ADDR_WIDTH];
                    req_op_d    = head[DATA_WIDTH+1 -: 2];
                    req_data_d  = head[DATA_WIDTH-1:0];
                    retry_cnt_d = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.debug_req_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the timeout cycle takes priority over the timeout.
                if (bus.debug_resp_valid) begin
                    if (retry_ok) begin
                        backoff_d   = BO_W'(1) << retry_cnt_q;
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = ST_BACKOFF;
                    end else begin
                        rsp_status_d = (bus.debug_resp_bits_resp == 2'd1) ? 2'd2 : bus.debug_resp_bits_resp;
                        rsp_data_d   = bus.debug_resp_bits_data;
                        state_d      = ST_RSP;
                    end
                end else if (timer_expired) begin
                    rsp_status_d = 2'd1;
                    rsp_data_d   = '0;
                    state_d      = ST_RSP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_BACKOFF: begin
                if (backoff_q <= BO_W'(1)) begin
                    state_d = ST_REQ;
                end else begin
                    backoff_d = backoff_q - 1'b1;
                end
            end
            ST_RSP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            req_addr_q   <= '0;
            req_op_q     <= '0;
            req_data_q   <= '0;
            retry_cnt_q  <= '0;
            backoff_q    <= '0;
            timer_q      <= '0;
            rsp_status_q <= '0;
            rsp_data_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_op_q     <= req_op_d;
            req_data_q   <= req_data_d;
            retry_cnt_q  <= retry_cnt_d;
            backoff_q    <= backoff_d;
            timer_q      <= timer_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign bus.cmd_ready           = !full;
    assign bus.debug_req_valid     = (state_q == ST_REQ);
    assign bus.debug_req_bits_addr = req_addr_q;
    assign bus.debug_req_bits_op   = req_op_q;
    assign bus.debug_req_bits_data = req_data_q;
    assign bus.debug_resp_ready    = (state_q != ST_RSP);
    assign bus.rsp_valid           = (state_q == ST_RSP);
    assign bus.rsp_status          = rsp_status_q;
    assign bus.rsp_data            = rsp_data_q;
    assign bus.cmd_count           = count_q;
    assign bus.busy                = (state_q != ST_IDLE) || !empty;

`ifdef DMI_CMD_BRIDGE_STATS_EN
    logic        retry_evt, timeout_evt, done_evt;
    logic [15:0] stat_retries_q, stat_retries_d;
    logic [15:0] stat_timeouts_q, stat_timeouts_d;
    logic [31:0] stat_done_q, stat_done_d;

    assign retry_evt   = (state_q == ST_WAIT) && bus.debug_resp_valid && retry_ok;
    assign timeout_evt = (state_q == ST_WAIT) && !bus.debug_resp_valid && timer_expired;
    assign done_evt    = (state_q == ST_RSP) && bus.rsp_ready;

    always_comb begin
        stat_retries_d  = stat_retries_q;
        stat_timeouts_d = stat_timeouts_q;
        stat_done_d     = stat_done_q;
        if (retry_evt && (stat_retries_q != '1)) stat_retries_d = stat_retries_q + 16'd1;
        if (timeout_evt && (stat_timeouts_q != '1)) stat_timeouts_d = stat_timeouts_q + 16'd1;
        if (done_evt && (stat_done_q != '1)) stat_done_d = stat_done_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_retries_q  <= '0;
            stat_timeouts_q <= '0;
            stat_done_q     <= '0;
        end else begin
            stat_retries_q  <= stat_retries_d;
            stat_timeouts_q <= stat_timeouts_d;
            stat_done_q     <= stat_done_d;
        end
    end

    assign bus.stat_retries  = stat_retries_q;
    assign bus.stat_timeouts = stat_timeouts_q;
    assign bus.stat_done     = stat_done_q;
`endif
endmodule

// File: tb/tb_dmi_cmd_bridge.sv
// tb/tb_dmi_cmd_bridge.sv - scoreboard bench for dmi_cmd_bridge with a scripted debug-module responder
module tb_dmi_cmd_bridge;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rsp_seen = 0;
    int   rsp_cyc_last = 0;
    int   resp_cyc = 0;

    typedef struct { logic [6:0] addr; logic [1:0] op; logic [63:0] data; } req_t;
    typedef struct { logic [1:0] status; logic [63:0] data; } rsp_t;
    typedef struct { bit respond; int delay; logic [1:0] resp; logic [63:0] data; } act_t;

    req_t req_exp[$];
    rsp_t rsp_exp[$];
    act_t script[$];
    int   hs_cyc[$];

    dmi_cmd_bridge_if #(.DATA_WIDTH(64), .ADDR_WIDTH(7), .CMD_DEPTH(4)) bus ();

    dmi_cmd_bridge #(
        .DATA_WIDTH(64), .ADDR_WIDTH(7), .CMD_DEPTH(4), .RETRY_LIMIT(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Debug-module model: checks each request and plays the next scripted action
    initial begin
        act_t a;
        req_t r;
        bus.debug_req_ready      = 1'b1;
        bus.debug_resp_valid     = 1'b0;
        bus.debug_resp_bits_resp = 2'd0;
        bus.debug_resp_bits_data = 64'd0;
        forever begin
            @(negedge clk);
            if (!reset && bus.debug_req_valid && bus.debug_req_ready) begin
                hs_cyc.push_back(cyc);
                n_checks++;
                if (req_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_unexpected: got addr=%h op=%0d data=%h, required no request", bus.debug_req_bits_addr, bus.debug_req_bits_op, bus.debug_req_bits_data);
                end else begin
                    r = req_exp.pop_front();
                    if (bus.debug_req_bits_addr !== r.addr || bus.debug_req_bits_op !== r.op || bus.debug_req_bits_data !== r.data) begin
                        n_fail++;
                        $display("FAIL req_fields: got %h/%0d/%h, required %h/%0d/%h", bus.debug_req_bits_addr, bus.debug_req_bits_op, bus.debug_req_bits_data, r.addr, r.op, r.data);
                    end
                end
                if (script.size() != 0) begin
                    a = script.pop_front();
                    if (a.respond) begin
                        repeat (a.delay) @(posedge clk);
                        #1;
                        bus.debug_resp_valid     = 1'b1;
                        bus.debug_resp_bits_resp = a.resp;
                        bus.debug_resp_bits_data = a.data;
                        resp_cyc = cyc;
                        @(posedge clk);
                        #1;
                        bus.debug_resp_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Result monitor: pops the scoreboard on every rsp handshake
    always @(negedge clk) begin
        rsp_t e;
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            rsp_seen++;
            rsp_cyc_last = cyc;
            n_checks++;
            if (rsp_exp.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got status=%0d data=%h, required no result", bus.rsp_status, bus.rsp_data);
            end else begin
                e = rsp_exp.pop_front();
                if (bus.rsp_status !== e.status || bus.rsp_data !== e.data) begin
                    n_fail++;
                    $display("FAIL rsp_result: got status=%0d data=%h, required status=%0d data=%h", bus.rsp_status, bus.rsp_data, e.status, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_act(input bit respond, input int delay, input logic [1:0] resp, input logic [63:0] data);
        act_t a;
        a.respond = respond; a.delay = delay; a.resp = resp; a.data = data;
        script.push_back(a);
    endtask

    task automatic add_rsp(input logic [1:0] status, input logic [63:0] data);
        rsp_t e;
        e.status = status; e.data = data;
        rsp_exp.push_back(e);
    endtask

    task automatic send_cmd(input logic [6:0] addr, input logic [1:0] op, input logic [63:0] data, input int issues, output int acc);
        req_t r;
        bit ok = 1'b0;
        r.addr = addr; r.op = op; r.data = data;
        for (int i = 0; i < issues; i++) req_exp.push_back(r);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        acc = -1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                acc = cyc;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cmd_accept: got cmd_ready=0 for 64 cycles, required acceptance");
        end
    endtask

    task automatic wait_rsp(input int target, input int bound);
        for (int i = 0; i < bound && rsp_seen < target; i++) @(posedge clk);
        #1;
        n_checks++;
        if (rsp_seen != target) begin
            n_fail++;
            $display("FAIL rsp_wait: got %0d results, required %0d", rsp_seen, target);
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_op = '0; bus.cmd_data = '0;
        bus.rsp_ready = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        n_checks++;
        if ({bus.cmd_ready, bus.debug_resp_ready, bus.debug_req_valid, bus.rsp_valid, bus.busy} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 11000", {bus.cmd_ready, bus.debug_resp_ready, bus.debug_req_valid, bus.rsp_valid, bus.busy});
        end
        n_checks++;
        if (bus.cmd_count !== 3'd0 || bus.rsp_status !== 2'd0 || bus.rsp_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: got count=%0d status=%0d data=%h, required 0/0/0", bus.cmd_count, bus.rsp_status, bus.rsp_data);
        end
        n_checks++;
        if (bus.debug_req_bits_addr !== 7'd0 || bus.debug_req_bits_op !== 2'd0 || bus.debug_req_bits_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_req_bits: got %h/%0d/%h, required zeros", bus.debug_req_bits_addr, bus.debug_req_bits_op, bus.debug_req_bits_data);
        end
    endtask

    task automatic test_write();
        int acc, first = -1, base = rsp_seen;
        add_act(1'b1, 1, 2'd0, 64'd0);
        add_rsp(2'd0, 64'd0);
        send_cmd(7'h10, 2'd2, 64'h8000_0001, 1, acc);
        for (int i = 0; i < 20 && first < 0; i++) begin
            @(negedge clk);
            if (bus.debug_req_valid) first = cyc;
        end
        n_checks++;
        if (first - acc != 2) begin
            n_fail++;
            $display("FAIL write_req_latency: got %0d cycles, required 2", first - acc);
        end
        wait_rsp(base + 1, 50);
        n_checks++;
        if (rsp_cyc_last - resp_cyc != 1) begin
            n_fail++;
            $display("FAIL write_rsp_latency: got %0d cycles, required 1", rsp_cyc_last - resp_cyc);
        end
    endtask

    task automatic test_busy_retry();
        int acc, base = rsp_seen;
        hs_cyc.delete();
        add_act(1'b1, 1, 2'd3, 64'h1);
        add_act(1'b1, 1, 2'd3, 64'h2);
        add_act(1'b1, 1, 2'd0, 64'hABCD);
        add_rsp(2'd0, 64'hABCD);
        send_cmd(7'h11, 2'd1, 64'd0, 3, acc);
        wait_rsp(base + 1, 100);
        n_checks++;
        if (hs_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL retry_count: got %0d requests, required 3", hs_cyc.size());
        end else begin
            n_checks++;
            if (hs_cyc[1] - hs_cyc[0] != 3 || hs_cyc[2] - hs_cyc[1] != 4) begin
                n_fail++;
                $display("FAIL retry_backoff: got gaps %0d,%0d, required 3,4", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
            end
        end
    endtask

    task automatic test_busy_exhausted();
        int acc, base = rsp_seen;
        hs_cyc.delete();
        for (int i = 0; i < 4; i++) add_act(1'b1, 1, 2'd3, 64'h70 + 64'(i));
        add_rsp(2'd3, 64'h73);
        send_cmd(7'h12, 2'd1, 64'd0, 4, acc);
        wait_rsp(base + 1, 150);
        wait_clk(10);
        n_checks++;
        if (hs_cyc.size() != 4 || req_exp.size() != 0) begin
            n_fail++;
            $display("FAIL exhausted_requests: got %0d issued, %0d pending, required 4 issued, 0 pending", hs_cyc.size(), req_exp.size());
        end
    endtask

    task automatic test_timeout();
        int acc, base = rsp_seen;
        hs_cyc.delete();
        add_act(1'b1, 20, 2'd0, 64'hDEAD);
        add_rsp(2'd1, 64'd0);
        send_cmd(7'h13, 2'd1, 64'd0, 1, acc);
        wait_rsp(base + 1, 60);
        n_checks++;
        if (hs_cyc.size() != 1 || rsp_cyc_last - hs_cyc[0] != 17) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles after handshake, required 17", (hs_cyc.size() != 0) ? rsp_cyc_last - hs_cyc[0] : -1);
        end
        wait_clk(10);
        n_checks++;
        if (rsp_seen != base + 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL late_resp_drop: got %0d results busy=%b, required %0d results busy=0", rsp_seen - base, bus.busy, 1);
        end
        add_act(1'b1, 1, 2'd0, 64'h1234);
        add_rsp(2'd0, 64'h1234);
        send_cmd(7'h14, 2'd1, 64'd0, 1, acc);
        wait_rsp(base + 2, 50);
    endtask

    task automatic test_failed_status();
        int acc, base = rsp_seen;
        add_act(1'b1, 1, 2'd2, 64'h22);
        add_act(1'b1, 1, 2'd1, 64'h11);
        add_rsp(2'd2, 64'h22);
        add_rsp(2'd2, 64'h11);
        send_cmd(7'h20, 2'd2, 64'hFFFF_0000_1111_2222, 1, acc);
        send_cmd(7'h21, 2'd1, 64'd0, 1, acc);
        wait_rsp(base + 2, 100);
    endtask

    task automatic test_fifo_full();
        int acc, base = rsp_seen;
        bus.rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            add_act(1'b1, 1, 2'd0, 64'(i) << 8);
            add_rsp(2'd0, 64'(i) << 8);
        end
        for (int i = 1; i <= 5; i++) send_cmd(7'(i), 2'd1, 64'(i), 1, acc);
        wait_clk(4);
        n_checks++;
        if (bus.cmd_count !== 3'd4 || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fifo_full: got count=%0d ready=%b rsp_valid=%b, required 4/0/1", bus.cmd_count, bus.cmd_ready, bus.rsp_valid);
        end
        bus.rsp_ready = 1'b1;
        wait_rsp(base + 5, 200);
        n_checks++;
        if (bus.cmd_count !== 3'd0 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fifo_drain: got count=%0d ready=%b, required 0/1", bus.cmd_count, bus.cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        int acc, base, stale = 0;
        add_act(1'b0, 0, 2'd0, 64'd0);
        send_cmd(7'h30, 2'd1, 64'd0, 1, acc);
        send_cmd(7'h31, 2'd1, 64'd0, 0, acc);
        send_cmd(7'h32, 2'd1, 64'd0, 0, acc);
        wait_clk(2);
        n_checks++;
        if (bus.cmd_count !== 3'd2 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_queue: got count=%0d busy=%b, required 2/1", bus.cmd_count, bus.busy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.debug_req_valid !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_count !== 3'd0 || bus.cmd_ready !== 1'b1 || bus.debug_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got req_valid=%b rsp_valid=%b count=%0d cmd_ready=%b resp_ready=%b, required 0/0/0/1/1", bus.debug_req_valid, bus.rsp_valid, bus.cmd_count, bus.cmd_ready, bus.debug_resp_ready);
        end
        script.delete();
        req_exp.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.debug_req_valid || bus.busy) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL stale_after_reset: got %0d active cycles, required 0", stale);
        end
        @(posedge clk);
        #1;
        base = rsp_seen;
        add_act(1'b1, 1, 2'd0, 64'h5A5A);
        add_rsp(2'd0, 64'h5A5A);
        send_cmd(7'h33, 2'd1, 64'd0, 1, acc);
        wait_rsp(base + 1, 50);
    endtask

    initial begin
        test_reset();
        test_write();
        test_busy_retry();
        test_busy_exhausted();
        test_timeout();
        test_failed_status();
        test_fifo_full();
        test_reset_mid();
        wait_clk(5);
        n_checks++;
        if (rsp_exp.size() != 0 || req_exp.size() != 0 || script.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got rsp=%0d req=%0d script=%0d pending, required 0/0/0", rsp_exp.size(), req_exp.size(), script.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
